// File: rtl/alu_8bit_pkg.sv
// ============================================================================
// Module      : CPU_package
// Description : Shared ALU opcode and flag encodings for the CPU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package CPU_package;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOTA = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_CPR  = 4'd10
  } enum_alu_opcode_t;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
    logic parity;
  } struct_alu_flag_t;

endpackage

`default_nettype wire

// File: rtl/alu_8bit_if.sv
// ============================================================================
// Module      : alu_8bit_if
// Description : Operand/opcode inputs and registered result/flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_8bit_if;
  import CPU_package::*;

  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  input_carry;
  enum_alu_opcode_t      alu_opcode;
  logic [DATA_WIDTH-1:0] alu_out;
  struct_alu_flag_t      alu_out_flag;

  modport master (
    output in_a, in_b, input_carry, alu_opcode,
    input  alu_out, alu_out_flag
  );

  modport slave (
    input  in_a, in_b, input_carry, alu_opcode,
    output alu_out, alu_out_flag
  );

endinterface

`default_nettype wire

// File: rtl/alu_8bit_core.sv
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU datapath producing next result and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import CPU_package::*;
(
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  input_carry,
  input  enum_alu_opcode_t      opcode,
  output logic [DATA_WIDTH-1:0] next_result,
  output struct_alu_flag_t      next_flag
);

  localparam int c_MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_diff;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic                    w_sub_ovf;
  logic [DATA_WIDTH-1:0]   w_res;
  logic [DATA_WIDTH-1:0]   w_src;
  logic                    w_carry;
  logic                    w_ovf;
  logic                    w_valid;
  logic                    w_src_is_diff;

  assign w_sum  = {1'b0, in_a} + {1'b0, in_b} + {{DATA_WIDTH{1'b0}}, input_carry};
  assign w_diff = {1'b0, in_a} - {1'b0, in_b};
  assign w_prod = {{DATA_WIDTH{1'b0}}, in_a} * {{DATA_WIDTH{1'b0}}, in_b};
  assign w_sub_ovf = (in_a[c_MSB] != in_b[c_MSB]) && (w_diff[c_MSB] != in_a[c_MSB]);

  always_comb begin
    w_res         = '0;
    w_carry       = 1'b0;
    w_ovf         = 1'b0;
    w_valid       = 1'b1;
    w_src_is_diff = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res   = w_sum[c_MSB:0];
        w_carry = w_sum[DATA_WIDTH];
        w_ovf   = (in_a[c_MSB] == in_b[c_MSB]) && (w_sum[c_MSB] != in_a[c_MSB]);
      end
      OP_SUB: begin
        w_res   = w_diff[c_MSB:0];
        w_carry = w_diff[DATA_WIDTH];
        w_ovf   = w_sub_ovf;
      end
      OP_MUL: begin
        w_res   = w_prod[c_MSB:0];
        w_carry = |w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
        w_ovf   = w_carry;
      end
      OP_DIV: begin
        // Divide-by-zero saturates instead of letting X propagate.
        if (in_b == '0) begin
          w_res = '1;
          w_ovf = 1'b1;
        end else begin
          w_res = in_a / in_b;
        end
      end
      OP_AND:  w_res = in_a & in_b;
      OP_OR:   w_res = in_a | in_b;
      OP_XOR:  w_res = in_a ^ in_b;
      OP_NOTA: w_res = ~in_a;
      OP_SHL: begin
        w_res   = {in_a[c_MSB-1:0], 1'b0};
        w_carry = in_a[c_MSB];
      end
      OP_SHR: begin
        w_res   = {1'b0, in_a[c_MSB:1]};
        w_carry = in_a[0];
      end
      OP_CPR: begin
        if (in_a == in_b)     w_res = '0;
        else if (in_a > in_b) w_res = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        else                  w_res = '1;
        w_carry       = w_diff[DATA_WIDTH];
        w_ovf         = w_sub_ovf;
        w_src_is_diff = 1'b1;
      end
      default: w_valid = 1'b0;
    endcase
  end

  // Compare reports the flags of a - b rather than of its encoded result.
  assign w_src = w_src_is_diff ? w_diff[c_MSB:0] : w_res;

  always_comb begin
    next_result = '0;
    next_flag   = '0;
    if (w_valid) begin
      next_result        = w_res;
      next_flag.carry    = w_carry;
      next_flag.overflow = w_ovf;
      next_flag.zero     = (w_src == '0);
      next_flag.negative = w_src[c_MSB];
      next_flag.parity   = ^w_src;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_8bit.sv
// ============================================================================
// Module      : alu_8bit
// Description : Registered 8-bit ALU: alu_core plus async-reset output flops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_8bit
  import CPU_package::*;
(
  input  logic       clk,
  input  logic       rst_n,
  alu_8bit_if.slave  bus
);

  logic [DATA_WIDTH-1:0] w_next_result;
  struct_alu_flag_t      w_next_flag;
  logic [DATA_WIDTH-1:0] r_alu_out;
  struct_alu_flag_t      r_alu_flag;

  alu_core u_core (
    .in_a        (bus.in_a),
    .in_b        (bus.in_b),
    .input_carry (bus.input_carry),
    .opcode      (bus.alu_opcode),
    .next_result (w_next_result),
    .next_flag   (w_next_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_out  <= '0;
      r_alu_flag <= '0;
    end else begin
      r_alu_out  <= w_next_result;
      r_alu_flag <= w_next_flag;
    end
  end

  assign bus.alu_out      = r_alu_out;
  assign bus.alu_out_flag = r_alu_flag;

endmodule

`default_nettype wire

// File: tb/tb_alu_8bit.sv
// ============================================================================
// Module      : tb_alu_8bit
// Description : Self-checking bench for alu_8bit with directed and random ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_8bit;
  import CPU_package::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_8bit_if bus ();

  alu_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from arithmetic rules: returns {flags[4:0], result[7:0]}.
  function automatic logic [12:0] model(input int op, input int a, input int b, input int cin);
    int r;
    int fsrc;
    int sa;
    int sb;
    int s;
    logic c;
    logic v;
    logic [7:0] res;
    logic [7:0] f8;
    c = 1'b0;
    v = 1'b0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin
        r = a + b + cin; c = (r > 255); res = 8'(r % 256);
        s = sa + sb + cin; v = (s > 127) || (s < -128);
      end
      1: begin
        r = (a - b + 256) % 256; c = (a < b); res = 8'(r);
        s = sa - sb; v = (s > 127) || (s < -128);
      end
      2: begin r = a * b; c = (r > 255); v = c; res = 8'(r % 256); end
      3: begin
        if (b == 0) begin res = 8'd255; v = 1'b1; end
        else res = 8'(a / b);
      end
      4: res = 8'(a & b);
      5: res = 8'(a | b);
      6: res = 8'(a ^ b);
      7: res = 8'(255 - a);
      8: begin res = 8'((a * 2) % 256); c = (a >= 128); end
      9: begin res = 8'(a / 2); c = (a % 2 == 1); end
      10: begin
        res = (a == b) ? 8'd0 : ((a > b) ? 8'd1 : 8'd255);
        c = (a < b);
        s = sa - sb; v = (s > 127) || (s < -128);
      end
      default: return 13'd0;
    endcase
    fsrc = (op == 10) ? (a - b + 256) % 256 : int'(res);
    f8 = 8'(fsrc);
    return {c, v, (fsrc == 0), (fsrc >= 128), ^f8, res};
  endfunction

  task automatic drive(input int op, input int a, input int b, input int cin);
    @(negedge clk);
    bus.alu_opcode  = enum_alu_opcode_t'(op[3:0]);
    bus.in_a        = a[7:0];
    bus.in_b        = b[7:0];
    bus.input_carry = cin[0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.alu_out_flag, bus.alu_out} !== 13'd0) begin
      failures++;
      $display("FAIL reset_init actual=%h required=%h", {bus.alu_out_flag, bus.alu_out}, 13'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(2, 12, 2, 0);
    checks++;
    if ({bus.alu_out_flag, bus.alu_out} !== {5'b00000, 8'd24}) begin
      failures++;
      $display("FAIL reset_pre_mul actual=%h required=%h", {bus.alu_out_flag, bus.alu_out}, {5'b00000, 8'd24});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.alu_out_flag, bus.alu_out} !== 13'd0) begin
      failures++;
      $display("FAIL reset_async actual=%h required=%h", {bus.alu_out_flag, bus.alu_out}, 13'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.alu_out_flag, bus.alu_out} !== 13'd0) begin
      failures++;
      $display("FAIL reset_hold actual=%h required=%h", {bus.alu_out_flag, bus.alu_out}, 13'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.alu_out_flag, bus.alu_out} !== {5'b00000, 8'd24}) begin
      failures++;
      $display("FAIL reset_release actual=%h required=%h", {bus.alu_out_flag, bus.alu_out}, {5'b00000, 8'd24});
    end
  endtask

  // Directed table: op, a, b, cin, flags {c,v,z,n,p}, result.
  task automatic test_directed;
    int          tab [15][4] = '{
      '{4, 1, 1, 0}, '{5, 1, 0, 0}, '{2, 10, 20, 0}, '{3, 10, 2, 0}, '{3, 7, 0, 0},
      '{7, 10, 0, 0}, '{10, 2, 2, 0}, '{10, 20, 10, 0}, '{10, 2, 10, 0},
      '{9, 4, 0, 0}, '{8, 4, 0, 0}, '{8, 129, 0, 0}, '{9, 1, 0, 0},
      '{0, 255, 1, 0}, '{0, 127, 0, 1}};
    logic [12:0] exp_tab [15] = '{
      {5'b00001, 8'd1}, {5'b00001, 8'd1}, {5'b00011, 8'd200}, {5'b00000, 8'd5},
      {5'b01010, 8'hFF}, {5'b00010, 8'd245}, {5'b00100, 8'h00}, {5'b00000, 8'h01},
      {5'b10011, 8'hFF}, {5'b00001, 8'd2}, {5'b00001, 8'd8}, {5'b10001, 8'h02},
      {5'b10100, 8'h00}, {5'b10100, 8'h00}, {5'b01011, 8'h80}};
    for (int i = 0; i < 15; i++) begin
      drive(tab[i][0], tab[i][1], tab[i][2], tab[i][3]);
      checks++;
      if ({bus.alu_out_flag, bus.alu_out} !== exp_tab[i]) begin
        failures++;
        $display("FAIL directed[%0d] op=%0d a=%0d b=%0d actual=%h required=%h",
                 i, tab[i][0], tab[i][1], tab[i][2], {bus.alu_out_flag, bus.alu_out}, exp_tab[i]);
      end
    end
  endtask

  task automatic test_add_sweep;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 9; b++) begin
        drive(0, a, b, 0);
        checks++;
        if (bus.alu_out !== 8'(a + b) || bus.alu_out_flag.zero !== (a + b == 0)) begin
          failures++;
          $display("FAIL add_sweep a=%0d b=%0d actual=%0d z=%b required=%0d z=%b",
                   a, b, bus.alu_out, bus.alu_out_flag.zero, a + b, (a + b == 0));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int          ops [4] = '{0, 1, 6, 12};
    logic [12:0] prev;
    logic [12:0] exp;
    int          a;
    int          b;
    int          cin;
    prev = {bus.alu_out_flag, bus.alu_out};
    for (int i = 0; i < 4; i++) begin
      a   = int'($urandom_range(1, 255));
      b   = int'($urandom_range(1, 255));
      cin = int'($urandom_range(0, 1));
      exp = model(ops[i], a, b, cin);
      @(negedge clk);
      bus.alu_opcode  = enum_alu_opcode_t'(ops[i][3:0]);
      bus.in_a        = a[7:0];
      bus.in_b        = b[7:0];
      bus.input_carry = cin[0];
      #1;
      checks++;
      if ({bus.alu_out_flag, bus.alu_out} !== prev) begin
        failures++;
        $display("FAIL b2b_early op=%0d actual=%h required=%h", ops[i], {bus.alu_out_flag, bus.alu_out}, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.alu_out_flag, bus.alu_out} !== exp) begin
        failures++;
        $display("FAIL b2b op=%0d a=%0d b=%0d actual=%h required=%h", ops[i], a, b, {bus.alu_out_flag, bus.alu_out}, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_random;
    logic [12:0] exp;
    int          op;
    int          a;
    int          b;
    int          cin;
    for (int i = 0; i < 300; i++) begin
      op  = int'($urandom_range(0, 15));
      a   = int'($urandom_range(0, 255));
      b   = (i % 10 == 0) ? 0 : int'($urandom_range(0, 255));
      cin = int'($urandom_range(0, 1));
      exp = model(op, a, b, cin);
      drive(op, a, b, cin);
      checks++;
      if ({bus.alu_out_flag, bus.alu_out} !== exp) begin
        failures++;
        $display("FAIL random op=%0d a=%0d b=%0d cin=%0d actual=%h required=%h",
                 op, a, b, cin, {bus.alu_out_flag, bus.alu_out}, exp);
      end
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.alu_opcode  = OP_MUL;
    bus.in_a        = 8'd12;
    bus.in_b        = 8'd2;
    bus.input_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_add_sweep();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit registered ALU for the CPU datapath.
- Takes two operands, a carry-in and an opcode. Produces an 8-bit result and a 5-bit flag struct, both registered on the clock.
- Shared types (opcode enum, flag struct, data width) live in CPU_package so the decoder and register file use identical encodings.

Parameters:
- DATA_WIDTH, 8, operand/result width. A package constant, not a module parameter; all behaviour below assumes 8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_a  input  DATA_WIDTH  operand A
- in_b  input  DATA_WIDTH  operand B
- input_carry  input  1  carry-in, used by ADD only
- alu_opcode  input  enum_alu_opcode_t (4 bits)  operation select
- alu_out  output  DATA_WIDTH  registered result
- alu_out_flag  output  struct_alu_flag_t (5 bits)  registered flags

Behaviour:
- Reset: when rst_n is low, alu_out = 8'h00 and alu_out_flag = 5'b0 immediately, independent of clk. Outputs hold 0 until the first rising clk edge after rst_n rises.
- Result path: combinational result/flags computed from the current inputs, captured on each rising clk. Latency is exactly 1 cycle; a new operation can start every cycle. No handshake, no enable.
- Flag struct, packed MSB to LSB: carry, overflow, zero, negative, parity.
  - zero = (result == 0).
  - negative = result[7].
  - parity = XOR of all result bits.
  - carry and overflow are set per opcode as listed below; otherwise 0.
- Opcodes (4-bit):
  - ADD=0: {carry, result} = a + b + input_carry. overflow = signed overflow.
  - SUB=1: result = a - b. carry = borrow (a < b unsigned). overflow = signed overflow.
  - MUL=2: result = low 8 bits of a*b (unsigned). carry = overflow = (high byte != 0).
  - DIV=3: result = a / b (unsigned, truncating).
    - If b == 0: result = 8'hFF and overflow = 1.
  - AND=4: result = a & b.
  - OR=5: result = a | b.
  - XOR=6: result = a ^ b.
  - NOTA=7: result = ~a. in_b is ignored.
  - SHL=8: result = a << 1, LSB filled with 0. carry = a[7].
  - SHR=9: result = a >> 1 (logical), MSB filled with 0. carry = a[0].
  - CPR=10: compare.
    - result = 8'h00 if a == b, 8'h01 if a > b, 8'hFF if a < b (unsigned).
    - Flags are those of a - b: zero = (a == b), carry = (a < b), negative = (a - b)[7], overflow = signed overflow of a - b, parity of a - b.
  - 11 to 15: reserved. result = 0 and all flags 0, including zero.
- input_carry is ignored by every opcode except ADD.
- Reset asserted mid-stream: the current operation is discarded and outputs go to 0 asynchronously.

Decomposition:
- CPU_package:
  - DATA_WIDTH
  - enum_alu_opcode_t: 4-bit enum with the encodings above
  - struct_alu_flag_t: packed struct with the field order above
- One combinational sub-module, alu_core: inputs in_a, in_b, input_carry, opcode; outputs next result and next flags.
- alu_8bit is alu_core plus the async-reset output registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with in_a=12, in_b=2, MUL applied. Required: alu_out = 0 and flags = 0 immediately. After release, the next edge gives alu_out = 24, flags = 0 (parity of 0x18 = 0).
- Logic/MUL/DIV (1-cycle latency):
  - AND 1,1 → 1, parity = 1.
  - OR 1,0 → 1.
  - MUL 10,20 → 200, negative = 1, carry = 0.
  - DIV 10,2 → 5.
  - DIV 7,0 → 0xFF, overflow = 1.
  - NOTA 10 → 245.
- Compare:
  - CPR 2,2 → 0x00, zero = 1.
  - CPR 20,10 → 0x01, carry = 0.
  - CPR 2,10 → 0xFF, carry = 1, negative = 1.
- ADD sweep: a = 0..15, b = 0..8, input_carry = 0. Required: alu_out = a+b one cycle after apply, zero = 1 only at 0+0.
  - Also 0xFF + 0x01 → 0x00, carry = 1, zero = 1.
  - Also 0x7F + 0x00 with input_carry = 1 → 0x80, overflow = 1.
- Shifts:
  - SHR 4 → 2.
  - SHL 4 → 8.
  - SHL 0x81 → 0x02, carry = 1.
  - SHR 0x01 → 0x00, carry = 1, zero = 1.
- Back-to-back: change opcode every cycle (ADD, SUB, XOR, reserved 12). Required: each result appears exactly one edge later. Reserved opcode gives result 0 with all flags 0.
